// File: rtl/inv_chain_pkg.sv
// Shared types and constants for the inverter-chain monitor.
// Error bit positions, the monitor FSM states and the pending-edge FIFO entry layout.
package inv_chain_pkg;

   localparam int ERR_SPUR = 0;
   localparam int ERR_POL  = 1;
   localparam int ERR_OVF  = 2;
   localparam int ERR_TMO  = 3;

   localparam int WARMUP_CYCLES = 3;

   // Widest timestamp the FIFO entry can carry; the top stores CNT_W bits zero-extended.
   localparam int MAX_CNT_W = 32;

   typedef enum logic {
      WARMUP = 1'b0,
      TRACK  = 1'b1
   } state_t;

   typedef struct packed {
      logic [MAX_CNT_W-1:0] ts;
      logic                 level;
   } fifo_entry_t;

endpackage

// File: rtl/inv_chain_monitor_edge_sync.sv
// Two-flop synchronizer plus history flop for one asynchronous level.
// Edge is visible 2-3 cycles after the raw change; no backpressure.
module edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic edge_pulse
);

   logic s1_q, s2_q, hist_q;
   logic s1_d, s2_d, hist_d;

   always_comb begin
      s1_d   = din;
      s2_d   = s1_q;
      hist_d = s2_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         hist_q <= 1'b0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         hist_q <= hist_d;
      end
   end

   assign level      = s2_q;
   assign edge_pulse = s2_q ^ hist_q;

endmodule

// File: rtl/inv_chain_monitor.sv
// Matches chain stimulus edges to chain output edges: latency, polarity, spurious/missing/overflow errors.
// Results registered one cycle after edge detection; no backpressure, edges beyond the FIFO are dropped and counted.
module inv_chain_monitor #(
   parameter int CNT_W   = 16,
   parameter int DEPTH   = 4,
   parameter int INVERT  = 1,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             chain_in,
   input  logic             chain_out,
   output logic             lat_valid,
   output logic [CNT_W-1:0] lat_cycles,
   output logic [CNT_W-1:0] max_lat,
   output logic [CNT_W-1:0] edge_count,
   output logic [CNT_W-1:0] err_count,
   output logic [3:0]       err_flags
);
   import inv_chain_pkg::*;

   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(TIMEOUT);
   localparam logic             INV_BIT  = (INVERT != 0);
   localparam logic [1:0]       WARM_END = 2'(WARMUP_CYCLES - 1);

   logic in_lvl, in_edge, out_lvl, out_edge;

   edge_sync u_sync_in (
      .clk        (clk),
      .rst        (reset),
      .din        (chain_in),
      .level      (in_lvl),
      .edge_pulse (in_edge)
   );

   edge_sync u_sync_out (
      .clk        (clk),
      .rst        (reset),
      .din        (chain_out),
      .level      (out_lvl),
      .edge_pulse (out_edge)
   );

   state_t     state_q, state_d;
   logic [1:0] warm_q, warm_d;
   logic       track_en;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= WARMUP;
         warm_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         warm_q  <= warm_d;
      end
   end

   // Warm-up lets the synchronizer history settle so reset-release levels never count as edges.
   always_comb begin
      state_d = state_q;
      warm_d  = warm_q;
      if (state_q == WARMUP) begin
         if (warm_q == WARM_END) begin
            state_d = TRACK;
            warm_d  = 2'd0;
         end else begin
            warm_d = warm_q + 2'd1;
         end
      end
   end

   always_comb begin
      track_en = (state_q == TRACK);
   end

   logic [CNT_W-1:0] ts_q, ts_d;
   fifo_entry_t      fifo_q [DEPTH];
   fifo_entry_t      fifo_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   cnt_q, cnt_d;

   logic             lat_valid_q, lat_valid_d;
   logic [CNT_W-1:0] lat_cycles_q, lat_cycles_d;
   logic [CNT_W-1:0] max_lat_q, max_lat_d;
   logic [CNT_W-1:0] edge_count_q, edge_count_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;
   logic [3:0]       err_flags_q, err_flags_d;

   fifo_entry_t      head;
   fifo_entry_t      push_entry;
   logic [CNT_W-1:0] head_age;
   logic             fifo_empty;
   logic             do_pop, do_push;
   logic             spur, pol, ovf, tmo;
   logic [2:0]       err_inc;
   logic [CNT_W:0]   err_sum;
   logic [3:0]       new_flags;

   always_comb begin
      ts_d         = ts_q + CNT_W'(1);
      fifo_d       = fifo_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      cnt_d        = cnt_q;
      lat_valid_d  = 1'b0;
      lat_cycles_d = lat_cycles_q;
      max_lat_d    = max_lat_q;
      edge_count_d = edge_count_q;
      err_count_d  = err_count_q;
      err_flags_d  = err_flags_q;
      do_pop       = 1'b0;
      do_push      = 1'b0;
      spur         = 1'b0;
      pol          = 1'b0;
      ovf          = 1'b0;
      tmo          = 1'b0;
      new_flags    = 4'b0000;

      head       = fifo_q[rd_ptr_q];
      head_age   = CNT_W'(MAX_CNT_W'(ts_q) - head.ts);
      fifo_empty = (cnt_q == '0);
      push_entry = '{ts: MAX_CNT_W'(ts_q), level: in_lvl};

      if (track_en) begin
         if (out_edge) begin
            if (fifo_empty) begin
               spur = 1'b1;
            end else begin
               do_pop       = 1'b1;
               lat_valid_d  = 1'b1;
               lat_cycles_d = head_age;
               if (head_age > max_lat_q) begin
                  max_lat_d = head_age;
               end
               if (edge_count_q != '1) begin
                  edge_count_d = edge_count_q + CNT_W'(1);
               end
               pol = (out_lvl != (head.level ^ INV_BIT));
            end
         end else if (!fifo_empty && (head_age > TMO_LIM)) begin
            do_pop = 1'b1;
            tmo    = 1'b1;
         end

         // Fullness is judged after this cycle's pop, so a pop frees room for a same-cycle push.
         if (in_edge) begin
            if ((cnt_q - (PTR_W+1)'(do_pop)) == FULL_CNT) begin
               ovf = 1'b1;
            end else begin
               do_push = 1'b1;
            end
         end
      end

      if (do_push) begin
         fifo_d[wr_ptr_q] = push_entry;
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      cnt_d = cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);

      new_flags[ERR_SPUR] = spur;
      new_flags[ERR_POL]  = pol;
      new_flags[ERR_OVF]  = ovf;
      new_flags[ERR_TMO]  = tmo;
      err_flags_d         = err_flags_q | new_flags;

      err_inc = {2'b00, spur} + {2'b00, pol} + {2'b00, ovf} + {2'b00, tmo};
      err_sum = {1'b0, err_count_q} + (CNT_W+1)'(err_inc);
      if (err_sum[CNT_W]) begin
         err_count_d = '1;
      end else begin
         err_count_d = err_sum[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ts_q     <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
         lat_valid_q  <= 1'b0;
         lat_cycles_q <= '0;
         max_lat_q    <= '0;
         edge_count_q <= '0;
         err_count_q  <= '0;
         err_flags_q  <= 4'b0000;
      end else begin
         ts_q         <= ts_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         fifo_q       <= fifo_d;
         lat_valid_q  <= lat_valid_d;
         lat_cycles_q <= lat_cycles_d;
         max_lat_q    <= max_lat_d;
         edge_count_q <= edge_count_d;
         err_count_q  <= err_count_d;
         err_flags_q  <= err_flags_d;
      end
   end

   assign lat_valid  = lat_valid_q;
   assign lat_cycles = lat_cycles_q;
   assign max_lat    = max_lat_q;
   assign edge_count = edge_count_q;
   assign err_count  = err_count_q;
   assign err_flags  = err_flags_q;

endmodule

// File: tb/tb_inv_chain_monitor.sv
// Directed bench for inv_chain_monitor: event-queue reference model checked every cycle,
// plus literal end-of-scenario expectations.
module tb_inv_chain_monitor;

   localparam int W       = 16;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 64;
   localparam int SAT     = 65535;

   logic          clk       = 1'b0;
   logic          reset     = 1'b1;
   logic          chain_in  = 1'b0;
   logic          chain_out = 1'b0;
   logic          lat_valid;
   logic [W-1:0]  lat_cycles, max_lat, edge_count, err_count;
   logic [3:0]    err_flags;

   inv_chain_monitor #(
      .CNT_W   (W),
      .DEPTH   (DEPTH),
      .INVERT  (1),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .chain_in   (chain_in),
      .chain_out  (chain_out),
      .lat_valid  (lat_valid),
      .lat_cycles (lat_cycles),
      .max_lat    (max_lat),
      .edge_count (edge_count),
      .err_count  (err_count),
      .err_flags  (err_flags)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   // Reference model: pending stimulus edges as (detect cycle, level) queues.
   int       q_t[$];
   bit       q_l[$];
   bit       m_vld;
   int       m_lat, m_max, m_edge, m_err;
   bit [3:0] m_flags;
   bit       in_h[4];
   bit       out_h[4];
   int       wcnt;
   int       now;

   int pulses     = 0;
   int pulse_base = 0;

   bit       lit_req = 1'b0;
   bit       lit_ack = 1'b0;
   string    lit_name;
   int       lit_edge, lit_err, lit_max, lit_lat, lit_pulses;
   bit [3:0] lit_flags;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      q_t.delete();
      q_l.delete();
      m_vld   = 1'b0;
      m_lat   = 0;
      m_max   = 0;
      m_edge  = 0;
      m_err   = 0;
      m_flags = 4'b0000;
      wcnt    = 0;
      for (int i = 0; i < 4; i++) begin
         in_h[i]  = 1'b0;
         out_h[i] = 1'b0;
      end
   endtask

   // One call per monitor cycle; a raw change sampled now is acted on two calls later.
   task automatic model_step();
      bit ie, oe, lvl;
      int t, age, nerr;
      now++;
      for (int i = 3; i > 0; i--) begin
         in_h[i]  = in_h[i-1];
         out_h[i] = out_h[i-1];
      end
      in_h[0]  = chain_in;
      out_h[0] = chain_out;
      ie    = in_h[2] ^ in_h[3];
      oe    = out_h[2] ^ out_h[3];
      m_vld = 1'b0;
      nerr  = 0;
      if (wcnt < 3) begin
         wcnt++;
      end else begin
         if (oe) begin
            if (q_t.size() == 0) begin
               m_flags[0] = 1'b1;
               nerr++;
            end else begin
               t      = q_t.pop_front();
               lvl    = q_l.pop_front();
               m_vld  = 1'b1;
               m_lat  = now - t;
               if (m_lat > m_max) m_max = m_lat;
               if (m_edge < SAT) m_edge++;
               if (out_h[2] == lvl) begin
                  m_flags[1] = 1'b1;
                  nerr++;
               end
            end
         end else if (q_t.size() > 0) begin
            age = now - q_t[0];
            if (age > TIMEOUT) begin
               void'(q_t.pop_front());
               void'(q_l.pop_front());
               m_flags[3] = 1'b1;
               nerr++;
            end
         end
         if (ie) begin
            if (q_t.size() >= DEPTH) begin
               m_flags[2] = 1'b1;
               nerr++;
            end else begin
               q_t.push_back(now);
               q_l.push_back(in_h[2]);
            end
         end
         m_err = (m_err + nerr > SAT) ? SAT : m_err + nerr;
      end
   endtask

   always @(negedge clk) begin
      if (reset) model_clear();
      chk("lat_valid",  32'(lat_valid),  32'(m_vld));
      chk("lat_cycles", 32'(lat_cycles), 32'(m_lat));
      chk("max_lat",    32'(max_lat),    32'(m_max));
      chk("edge_count", 32'(edge_count), 32'(m_edge));
      chk("err_count",  32'(err_count),  32'(m_err));
      chk("err_flags",  32'(err_flags),  32'(m_flags));
      if (lat_valid === 1'b1) pulses++;
      if (lit_req != lit_ack) begin
         lit_ack = lit_req;
         chk({lit_name, " edge_count"}, 32'(edge_count), 32'(lit_edge));
         chk({lit_name, " err_count"},  32'(err_count),  32'(lit_err));
         chk({lit_name, " err_flags"},  32'(err_flags),  32'(lit_flags));
         chk({lit_name, " max_lat"},    32'(max_lat),    32'(lit_max));
         chk({lit_name, " lat_cycles"}, 32'(lat_cycles), 32'(lit_lat));
         chk({lit_name, " pulses"},     32'(pulses - pulse_base), 32'(lit_pulses));
         pulse_base = pulses;
      end
      if (!reset) model_step();
   end

   task automatic wait_cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      wait_cyc(6);
   endtask

   task automatic lit_check(input string nm, input int e_edge, input int e_err,
                            input bit [3:0] e_flags, input int e_max, input int e_lat,
                            input int e_pulses);
      lit_name   = nm;
      lit_edge   = e_edge;
      lit_err    = e_err;
      lit_flags  = e_flags;
      lit_max    = e_max;
      lit_lat    = e_lat;
      lit_pulses = e_pulses;
      lit_req    = ~lit_req;
      wait_cyc(2);
   endtask

   // Square wave of ne edges on chain_in; chain_out repeats each toggle dly cycles later.
   task automatic run_wave(input int hp, input int ne, input int dly, input bit inv);
      chain_in  = 1'b0;
      chain_out = inv;
      do_reset();
      for (int c = 0; c <= hp * ne + dly; c++) begin
         if ((c % hp) == 0 && c < hp * ne) chain_in = ~chain_in;
         if (c >= dly && ((c - dly) % hp) == 0 && (c - dly) < hp * ne) chain_out = ~chain_out;
         wait_cyc(1);
      end
      wait_cyc(20);
   endtask

   initial begin
      now = 0;
      model_clear();
      wait_cyc(3);

      run_wave(10, 8, 5, 1'b1);
      lit_check("inv_wave", 8, 0, 4'b0000, 5, 5, 8);

      run_wave(10, 8, 5, 1'b0);
      lit_check("polarity", 8, 8, 4'b0010, 5, 5, 8);

      run_wave(5, 10, 50, 1'b1);
      lit_check("overflow", 4, 12, 4'b0101, 50, 50, 4);

      chain_in  = 1'b0;
      chain_out = 1'b1;
      do_reset();
      chain_out = ~chain_out;
      wait_cyc(20);
      lit_check("spurious", 0, 1, 4'b0001, 0, 0, 0);

      chain_in  = 1'b0;
      chain_out = 1'b1;
      do_reset();
      chain_in = ~chain_in;
      wait_cyc(80);
      lit_check("timeout", 0, 1, 4'b1000, 0, 0, 0);
      chain_out = ~chain_out;
      wait_cyc(10);
      lit_check("after_timeout", 0, 2, 4'b1001, 0, 0, 0);

      chain_in  = 1'b0;
      chain_out = 1'b1;
      do_reset();
      chain_in = ~chain_in;
      wait_cyc(2);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      chain_out = ~chain_out;
      wait_cyc(20);
      lit_check("mid_reset", 0, 0, 4'b0000, 0, 0, 0);
      chain_out = ~chain_out;
      wait_cyc(10);
      lit_check("reset_flush", 0, 1, 4'b0001, 0, 0, 0);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
